// File: rtl/seq_mag_comp.sv
// seq_mag_comp: multi-cycle MSB-first magnitude comparator, one CHUNK-bit slice per clock.
// Define CMP_EARLY_EXIT_EN to finish on the first differing slice.
module seq_mag_comp #(
  parameter int W     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_mode,
  output logic         busy,
  output logic         done,
  output logic         e,
  output logic         l,
  output logic         g
);
  localparam int NSLICE = W / CHUNK;
  localparam int IW     = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [W-1:0]     r_a, r_b, w_flip;
  logic [IW-1:0]    r_idx;
  logic             r_dec, r_lt;
  logic [CHUNK-1:0] w_sa, w_sb;
  logic             w_diff, w_last, w_lt, w_gt;
  // Flipping the sign bit maps two's complement onto offset binary, so slices compare unsigned.
  assign w_flip = signed_mode ? {1'b1, {(W-1){1'b0}}} : '0;
  assign w_sa   = CHUNK'(r_a >> (CHUNK * r_idx));
  assign w_sb   = CHUNK'(r_b >> (CHUNK * r_idx));
  assign w_diff = w_sa != w_sb;
  assign w_lt   = r_dec ? r_lt  : w_diff && (w_sa < w_sb);
  assign w_gt   = r_dec ? !r_lt : w_diff && (w_sa > w_sb);
`ifdef CMP_EARLY_EXIT_EN
  assign w_last = (r_idx == '0) || (!r_dec && w_diff);
`else
  assign w_last = r_idx == '0;
`endif
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  always_comb
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_dec   <= 1'b0;
      r_lt    <= 1'b0;
      e       <= 1'b0;
      l       <= 1'b0;
      g       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_a   <= a ^ w_flip;
        r_b   <= b ^ w_flip;
        r_idx <= IW'(NSLICE - 1);
        r_dec <= 1'b0;
        r_lt  <= 1'b0;
      end
      if (r_state == RUN) begin
        r_idx <= r_idx - 1'b1;
        if (!r_dec && w_diff) begin
          r_dec <= 1'b1;
          r_lt  <= w_sa < w_sb;
        end
        if (w_last) begin
          e <= !(w_lt || w_gt);
          l <= w_lt;
          g <= w_gt;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_mag_comp.sv
// tb_seq_mag_comp: cycle-by-cycle model comparison plus directed literal vectors for seq_mag_comp.
module tb_seq_mag_comp;
  localparam int W = 8, CHUNK = 2, NS = W / CHUNK;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, signed_mode = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, e, l, g;
  int errors = 0, checks = 0;
  bit en = 0;
  seq_mag_comp #(.W(W), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy), .done(done), .e(e), .l(l), .g(g));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: arithmetic compare, latency from the position of the first differing slice.
  int m_cnt = 0, m_lat;
  bit m_e, m_l, m_g, p_e, p_l, p_g;
  function automatic void model_calc(input logic [W-1:0] ta, tb, input logic sm);
    int va, vb, k;
    logic [W-1:0] ua, ub;
    va = sm ? int'($signed(ta)) : int'(ta);
    vb = sm ? int'($signed(tb)) : int'(tb);
    p_e = va == vb; p_l = va < vb; p_g = va > vb;
    ua = sm ? ta + 8'h80 : ta;
    ub = sm ? tb + 8'h80 : tb;
    k = NS;
    for (int i = NS - 1; i >= 0; i--)
      if (k == NS && ((ua >> (i * CHUNK)) % (1 << CHUNK)) != ((ub >> (i * CHUNK)) % (1 << CHUNK)))
        k = NS - i;
    m_lat = EE ? k : NS;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_e = 0; m_l = 0; m_g = 0;
    end else if (m_cnt == 0) begin
      if (start) begin
        model_calc(a, b, signed_mode);
        m_cnt = m_lat + 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_e = p_e; m_l = p_l; m_g = p_g;
      end
    end
  end
  always @(negedge clk) if (en) begin
    chk("model_busy", busy, m_cnt > 0);
    chk("model_done", done, m_cnt == 1);
    chk("model_e", e, m_e);
    chk("model_l", l, m_l);
    chk("model_g", g, m_g);
  end
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run(input logic [W-1:0] ta, tb, input logic sm, input int lat,
                     input logic xe, xl, xg);
    int n;
    @(negedge clk);
    a = ta; b = tb; signed_mode = sm; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(n);
    chk("lat", n, lat + 1);
    chk("done", done, 1);
    chk("e", e, xe);
    chk("l", l, xl);
    chk("g", g, xg);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_elg", {e, l, g}, 0);
    rst = 0;
    run(8'h5A, 8'h5A, 0, NS, 1, 0, 0);
    run(8'h80, 8'h7F, 0, EE ? 1 : NS, 0, 0, 1);
    run(8'h80, 8'h7F, 1, EE ? 1 : NS, 0, 1, 0);
    run(8'hFF, 8'h01, 1, EE ? 1 : NS, 0, 1, 0);
    run(8'h12, 8'h13, 0, NS, 0, 1, 0);
    run(8'hC0, 8'h40, 0, EE ? 1 : NS, 0, 0, 1);
    // Result holds through the next IDLE and RUN cycles.
    @(negedge clk);
    chk("hold_idle_g", g, 1);
    a = 8'h12; b = 8'h13; start = 1;
    @(negedge clk);
    start = 0;
    chk("hold_run_busy", busy, 1);
    chk("hold_run_g", g, 1);
    @(negedge clk);
    chk("hold_run_g2", g, 1);
    wait_done(n);
    chk("hold_next_l", l, 1);
    // Operands changed during RUN are ignored.
    @(negedge clk);
    a = 8'h01; b = 8'h02; signed_mode = 0; start = 1;
    @(negedge clk);
    start = 0; a = 8'hFF; b = 8'h00; signed_mode = 1;
    wait_done(n);
    chk("capture_l", l, 1);
    chk("capture_g", g, 0);
    // Start held high: one compare every NS+2 cycles.
    @(negedge clk);
    a = 8'h5A; b = 8'h5A; signed_mode = 0; start = 1;
    @(negedge clk);
    wait_done(n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    chk("held_period", n, NS + 2);
    start = 0;
    @(negedge clk);
    // Reset in the middle of a compare.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_elg", {e, l, g}, 0);
    run(8'hF0, 8'h0F, 0, EE ? 1 : NS, 0, 0, 1);
    run(8'hF0, 8'h0F, 1, EE ? 1 : NS, 0, 1, 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
